// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM encoding and width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // Bits needed to hold values 0..v-1 (minimum 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   pr,
  input  logic         in_bit,
  input  logic [N-1:0] divisor,
  output logic [N:0]   pr_next,
  output logic         q_bit
);

  logic [N:0] pr_shift;
  logic [N:0] diff;
  logic       no_borrow;

  assign pr_shift = {pr[N-1:0], in_bit};

  // pr_shift - divisor as pr_shift + ~divisor + 1; carry-out set means no borrow.
  RippleN #(.W(N+1)) u_sub (
    .a    (pr_shift),
    .b    (~{1'b0, divisor}),
    .cin  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  // pr[N] stays clear while pr < divisor; if it were set the shifted value
  // would exceed any divisor, so folding it in keeps the step total.
  assign q_bit   = no_borrow | pr[N];
  assign pr_next = q_bit ? diff : pr_shift;

endmodule

// File: rtl/ripple_n.sv
// W-bit ripple-carry adder built from a chain of full-adder cells.
module RippleN #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/seq_divider_2n_by_n.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module seq_divider_2n_by_n
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] Q,
  output logic [N-1:0]   R,
  output logic           div0
);

  localparam int CW = clog2(2*N);
  localparam logic [CW-1:0] LAST = CW'(2*N-1);

  div_state_e     state;
  logic [CW-1:0]  cnt;
  logic           fin;      // all 2N iterations done; next RUN edge writes back
  logic [2*N-1:0] dvd;
  logic [N-1:0]   dvs;
  logic [N:0]     pr;
  logic [2*N-1:0] quo;

  logic [N:0]     pr_next;
  logic           q_bit;

  div_step #(.N(N)) u_step (
    .pr      (pr),
    .in_bit  (dvd[2*N-1]),
    .divisor (dvs),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  // FSM, datapath shift registers and registered outputs.
  // Q/R/div0 change only on entry to DONE so they stay stable through a run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      fin   <= 1'b0;
      dvd   <= '0;
      dvs   <= '0;
      pr    <= '0;
      quo   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Q     <= '0;
      R     <= '0;
      div0  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd <= A;
            dvs <= B;
            pr  <= '0;
            cnt <= '0;
            fin <= 1'b0;
            quo <= '0;
            if (B == '0) begin
              state <= DONE;
              done  <= 1'b1;
              Q     <= '1;
              R     <= '0;
              div0  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!fin) begin
            dvd <= {dvd[2*N-2:0], 1'b0};
            pr  <= pr_next;
            quo <= {quo[2*N-2:0], q_bit};
            if (cnt == LAST) begin
              fin  <= 1'b1;
              busy <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= DONE;
            done  <= 1'b1;
            Q     <= quo;
            R     <= pr[N-1:0];
            div0  <= 1'b0;
            fin   <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_2n_by_n.sv
// Scoreboard bench for seq_divider_2n_by_n (N=4).
module tb_seq_divider_2n_by_n;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*N-1:0] A = '0;
  logic [N-1:0]   B = '0;
  logic           busy, done, div0;
  logic [2*N-1:0] Q;
  logic [N-1:0]   R;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  seq_divider_2n_by_n #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input int a, input int b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = 255; e.r = 0; e.z = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 0;
    end
    sb.push_back(e);
  endfunction

  // Result monitor: every done pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("Q", int'(Q), e.q);
        chk("R", int'(R), e.r);
        chk("div0", int'(div0), e.z);
        if (e.z == 0) begin
          chk("inv_qb_r", int'(Q) * e.b + int'(R), e.a);
          chk("inv_r_lt_b", int'(int'(R) < e.b), 1);
        end
      end
    end
  end

  // Issue one divide, check latency to done and busy length, return in first IDLE cycle.
  task automatic do_div(input int a, input int b, input int exp_lat, input int exp_busy);
    int bc;
    int lat;
    push_exp(a, b);
    A = 8'(a);
    B = 4'(b);
    start = 1'b1;
    bc = 0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
      if (busy) bc++;
      if (done) begin
        lat = k - 1;
        break;
      end
    end
    if (lat < 0) chk("timeout", 0, 1);
    else begin
      chk("latency", lat, exp_lat);
      chk("busy_cycles", bc, exp_busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_Q", int'(Q), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_div0", int'(div0), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic and extremes
    do_div(200, 7, 2*N+1, 2*N);
    do_div(255, 1, 2*N+1, 2*N);
    do_div(0, 15, 2*N+1, 2*N);
    do_div(255, 15, 2*N+1, 2*N);
    // Divide by zero: done right after acceptance, busy never high
    do_div(13, 0, 0, 0);

    // Start while busy is ignored
    push_exp(100, 3);
    A = 8'd100; B = 4'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    A = 8'd9; B = 4'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("ign_done_seen", seen, 1);
    repeat (12) begin @(posedge clk); #1; end
    chk("ign_sb_empty", sb.size(), 0);

    // Reset mid-run abandons the division
    push_exp(200, 7);
    A = 8'd200; B = 4'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_Q", int'(Q), 0);
    chk("mid_rst_R", int'(R), 0);
    chk("mid_rst_div0", int'(div0), 0);
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    do_div(50, 6, 2*N+1, 2*N);

    // Random back-to-back divides
    for (int i = 0; i < 1000; i++)
      do_div(int'($urandom_range(0, 255)), int'($urandom_range(1, 15)), 2*N+1, 2*N);

    // Round trip of a 4x4 product: (X*Y)/Y == X, remainder 0
    for (int i = 0; i < 40; i++) begin
      int x, y;
      x = int'($urandom_range(0, 15));
      y = int'($urandom_range(1, 15));
      do_div(x * y, y, 2*N+1, 2*N);
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
